// File: rtl/bp_cce_dir_entry_writer.sv
// Read-modify-write of one {tag, state} entry in a directory row held in a 1RW synchronous RAM.
// Optional macro BP_CCE_DIR_WR_BYPASS_EN: reuse the last written row instead of re-reading it.
module bp_cce_dir_entry_writer #(
    parameter int tag_sets_per_row_p = 2,
    parameter int assoc_p            = 8,
    parameter int tag_width_p        = 20,
    parameter int rows_p             = 64,
    localparam int lg_rows_lp        = (rows_p > 1) ? $clog2(rows_p) : 1,
    localparam int lg_assoc_lp       = (assoc_p > 1) ? $clog2(assoc_p) : 1,
    localparam int entry_width_lp    = tag_width_p + 3,
    localparam int row_width_p       = tag_sets_per_row_p * assoc_p * entry_width_lp
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [lg_rows_lp-1:0]  row_addr_i,
    input  logic                   set_sel_i,
    input  logic [lg_assoc_lp-1:0] way_i,
    input  logic [tag_width_p-1:0] tag_i,
    input  logic [2:0]             state_i,
    input  logic                   state_only_i,
    output logic                   ram_v_o,
    output logic                   ram_w_o,
    output logic [lg_rows_lp-1:0]  ram_addr_o,
    output logic [row_width_p-1:0] ram_data_o,
    input  logic [row_width_p-1:0] ram_data_i,
    output logic                   done_o
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;

    state_e                 state_r, state_n;
    logic                   accept;
    logic                   hit;
    logic [lg_rows_lp-1:0]  row_r;
    logic                   set_r;
    logic [lg_assoc_lp-1:0] way_r;
    logic [tag_width_p-1:0] tag_r;
    logic [2:0]             coh_r;
    logic                   state_only_r;
    logic [row_width_p-1:0] src_row;

    // Entry [set][way] is laid out at ((set*assoc_p)+way)*entry_width, state in the low 3 bits.
    function automatic logic [row_width_p-1:0] merge_entry(
        input logic [row_width_p-1:0] row,
        input logic                   set_sel,
        input logic [lg_assoc_lp-1:0] way,
        input logic [tag_width_p-1:0] tag,
        input logic [2:0]             coh,
        input logic                   state_only
    );
        logic [row_width_p-1:0] r;
        int                     base;
        r    = row;
        base = (int'(set_sel) * assoc_p + int'(way)) * entry_width_lp;
        if (!state_only)
            r[base+3 +: tag_width_p] = tag;
        r[base +: 3] = coh;
        return r;
    endfunction

`ifdef BP_CCE_DIR_WR_BYPASS_EN
    logic                   last_v_r;
    logic [lg_rows_lp-1:0]  last_addr_r;
    logic [row_width_p-1:0] last_row_r;
    logic                   bypass_r;

    assign hit     = last_v_r && (row_addr_i == last_addr_r);
    assign src_row = bypass_r ? last_row_r : ram_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            last_v_r <= 1'b0;
        else if (state_r == WR)
            last_v_r <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (state_r == WR) begin
            last_addr_r <= row_r;
            last_row_r  <= ram_data_o;
        end
        if (accept)
            bypass_r <= hit;
    end
`else
    assign hit     = 1'b0;
    assign src_row = ram_data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_r <= IDLE;
        else
            state_r <= state_n;
    end

    // Request fields are captured once at acceptance and held through RD/WR.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            row_r        <= row_addr_i;
            set_r        <= set_sel_i;
            way_r        <= way_i;
            tag_r        <= tag_i;
            coh_r        <= state_i;
            state_only_r <= state_only_i;
        end
    end

    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        ram_v_o = 1'b0;
        ram_w_o = 1'b0;
        done_o  = 1'b0;
        accept  = 1'b0;
        case (state_r)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) begin
                    accept  = 1'b1;
                    state_n = hit ? WR : RD;
                end
            end
            RD: begin
                ram_v_o = 1'b1;
                state_n = WR;
            end
            WR: begin
                ram_v_o = 1'b1;
                ram_w_o = 1'b1;
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ram_addr_o = row_r;
    assign ram_data_o = merge_entry(src_row, set_r, way_r, tag_r, coh_r, state_only_r);

endmodule

// File: tb/tb_bp_cce_dir_entry_writer.sv
// Bench for bp_cce_dir_entry_writer: directed table, corner sequences and randomized requests vs. a directory model.
module tb_bp_cce_dir_entry_writer;

    localparam int SETS = 2, ASSOC = 2, TW = 8, ROWS = 4;
    localparam int EW = TW + 3;
    localparam int RW = SETS * ASSOC * EW;
`ifdef BP_CCE_DIR_WR_BYPASS_EN
    localparam bit byp_build = 1'b1;
`else
    localparam bit byp_build = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic          ready_o;
    logic [1:0]    row_addr_i = '0;
    logic          set_sel_i = 1'b0;
    logic [0:0]    way_i = '0;
    logic [TW-1:0] tag_i = '0;
    logic [2:0]    state_i = '0;
    logic          state_only_i = 1'b0;
    logic          ram_v_o, ram_w_o, done_o;
    logic [1:0]    ram_addr_o;
    logic [RW-1:0] ram_data_o;
    logic [RW-1:0] ram_data_i = '0;
    logic [RW-1:0] mem [ROWS] = '{default: '0};

    int checks = 0;
    int errors = 0;

    logic [TW-1:0] m_tag [ROWS][SETS][ASSOC];
    logic [2:0]    m_st  [ROWS][SETS][ASSOC];
    bit            last_v_m = 1'b0;
    int            last_addr_m = 0;

    typedef struct {
        int            row;
        int            set;
        int            way;
        logic [TW-1:0] tag;
        logic [2:0]    st;
        bit            so;
        logic [TW-1:0] etag;
        logic [2:0]    est;
    } vec_t;

    bp_cce_dir_entry_writer #(
        .tag_sets_per_row_p(SETS), .assoc_p(ASSOC), .tag_width_p(TW), .rows_p(ROWS)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .row_addr_i(row_addr_i), .set_sel_i(set_sel_i), .way_i(way_i), .tag_i(tag_i),
        .state_i(state_i), .state_only_i(state_only_i),
        .ram_v_o(ram_v_o), .ram_w_o(ram_w_o), .ram_addr_o(ram_addr_o),
        .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .done_o(done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_v_o) begin
            if (ram_w_o) mem[ram_addr_o] <= ram_data_o;
            else         ram_data_i <= mem[ram_addr_o];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] pack_row(input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < ASSOC; w++)
                v[(s*ASSOC+w)*EW +: EW] = {m_tag[r][s][w], m_st[r][s][w]};
        return v;
    endfunction

    function automatic logic [EW-1:0] entry_of(input logic [RW-1:0] row, input int s, input int w);
        return row[(s*ASSOC+w)*EW +: EW];
    endfunction

    task automatic drive(input vec_t r);
        row_addr_i   = 2'(r.row);
        set_sel_i    = r.set[0];
        way_i        = r.way[0];
        tag_i        = r.tag;
        state_i      = r.st;
        state_only_i = r.so;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        v_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        last_v_m = 1'b0;
        chk("rst_ready", ready_o, 1);
        chk("rst_ram_v", ram_v_o, 0);
        chk("rst_done", done_o, 0);
    endtask

    // Entered and left at a negedge in IDLE; hold keeps v_i up with the next request's fields.
    task automatic run_req(input vec_t r, input bit hold, input vec_t nx, output logic [RW-1:0] wrow);
        bit byp;
        logic [RW-1:0] exp;
        byp = byp_build && last_v_m && (last_addr_m == r.row);
        chk("idle_ready", ready_o, 1);
        chk("idle_ram_v", ram_v_o, 0);
        chk("idle_done", done_o, 0);
        drive(r);
        v_i = 1'b1;
        if (!r.so) m_tag[r.row][r.set][r.way] = r.tag;
        m_st[r.row][r.set][r.way] = r.st;
        exp = pack_row(r.row);
        @(negedge clk);
        if (hold) drive(nx);
        else v_i = 1'b0;
        if (!byp) begin
            chk("rd_ram_v", ram_v_o, 1);
            chk("rd_ram_w", ram_w_o, 0);
            chk("rd_addr", ram_addr_o, r.row);
            chk("rd_ready", ready_o, 0);
            chk("rd_done", done_o, 0);
            @(negedge clk);
        end
        chk("wr_ram_v", ram_v_o, 1);
        chk("wr_ram_w", ram_w_o, 1);
        chk("wr_addr", ram_addr_o, r.row);
        chk("wr_ready", ready_o, 0);
        chk("wr_done", done_o, 1);
        chk("wr_data", ram_data_o, exp);
        wrow = ram_data_o;
        last_v_m = 1'b1;
        last_addr_m = r.row;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        vec_t a, b, cur, nxt;
        logic [RW-1:0] wrow;
        bit hold;

        for (int r = 0; r < ROWS; r++)
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < ASSOC; w++) begin
                    m_tag[r][s][w] = '0;
                    m_st[r][s][w]  = '0;
                end

        tbl[0] = '{row:1, set:1, way:0, tag:8'hA5, st:3'd3, so:1'b0, etag:8'hA5, est:3'd3};
        tbl[1] = '{row:0, set:0, way:1, tag:8'h3C, st:3'd2, so:1'b0, etag:8'h3C, est:3'd2};
        tbl[2] = '{row:0, set:0, way:1, tag:8'hFF, st:3'd0, so:1'b1, etag:8'h3C, est:3'd0};
        tbl[3] = '{row:3, set:1, way:1, tag:8'h77, st:3'd5, so:1'b0, etag:8'h77, est:3'd5};
        tbl[4] = '{row:3, set:1, way:1, tag:8'h12, st:3'd0, so:1'b0, etag:8'h12, est:3'd0};
        tbl[5] = '{row:1, set:0, way:1, tag:8'hEE, st:3'd7, so:1'b1, etag:8'h00, est:3'd7};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_req(tbl[i], 1'b0, tbl[i], wrow);
            chk($sformatf("tbl%0d_entry", i), entry_of(wrow, tbl[i].set, tbl[i].way), {tbl[i].etag, tbl[i].est});
        end

        // Back-to-back with v_i held: second accepted only once IDLE returns.
        a = '{row:2, set:0, way:0, tag:8'h5A, st:3'd1, so:1'b0, etag:8'h5A, est:3'd1};
        b = '{row:3, set:0, way:1, tag:8'hC3, st:3'd4, so:1'b0, etag:8'hC3, est:3'd4};
        run_req(a, 1'b1, b, wrow);
        chk("held_v_still_high", v_i, 1);
        run_req(b, 1'b0, b, wrow);

        // Reset during RD abandons the request.
        a = '{row:1, set:1, way:1, tag:8'h99, st:3'd6, so:1'b0, etag:8'h99, est:3'd6};
        do_reset();
        drive(a);
        v_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        chk("rstrd_ram_v", ram_v_o, 1);
        chk("rstrd_ram_w", ram_w_o, 0);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        last_v_m = 1'b0;
        chk("rstrd_ready", ready_o, 1);
        chk("rstrd_ram_v_idle", ram_v_o, 0);
        chk("rstrd_done", done_o, 0);
        @(negedge clk);
        chk("rstrd_done_after", done_o, 0);
        chk("rstrd_ram_v_after", ram_v_o, 0);
        chk("rstrd_row_untouched", mem[1], pack_row(1));

        // Two requests to the same row: read bypass only in the bypass build.
        do_reset();
        a = '{row:2, set:0, way:0, tag:8'h11, st:3'd1, so:1'b0, etag:8'h11, est:3'd1};
        b = '{row:2, set:1, way:1, tag:8'h22, st:3'd2, so:1'b0, etag:8'h22, est:3'd2};
        run_req(a, 1'b0, a, wrow);
        run_req(b, 1'b0, b, wrow);
        chk("same_row_e00", entry_of(wrow, 0, 0), {8'h11, 3'd1});
        chk("same_row_e11", entry_of(wrow, 1, 1), {8'h22, 3'd2});

        // Randomized requests against the directory model.
        cur = '{row:int'($urandom_range(0, 3)), set:int'($urandom_range(0, 1)), way:int'($urandom_range(0, 1)),
                tag:8'($urandom), st:3'($urandom), so:1'($urandom), etag:'0, est:'0};
        for (int i = 0; i < 60; i++) begin
            nxt = '{row:int'($urandom_range(0, 3)), set:int'($urandom_range(0, 1)), way:int'($urandom_range(0, 1)),
                    tag:8'($urandom), st:3'($urandom), so:1'($urandom), etag:'0, est:'0};
            hold = ($urandom_range(0, 2) == 0);
            run_req(cur, hold, nxt, wrow);
            if (!hold)
                repeat ($urandom_range(0, 2)) begin
                    chk("rnd_gap_ready", ready_o, 1);
                    @(negedge clk);
                end
            cur = nxt;
        end
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("final_row%0d", r), mem[r], pack_row(r));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_cce_dir_entry_writer.md
BP_CCE_DIR_ENTRY_WRITER -- requirements
Module: bp_cce_dir_entry_writer

Interface
REQ-001 SHALL have parameter tag_sets_per_row_p, default 2, tag sets per directory row; only 2 is supported.
REQ-002 SHALL have parameter assoc_p, default 8, ways per tag set.
REQ-003 SHALL have parameter tag_width_p, default 20, tag bits per entry.
REQ-004 SHALL have parameter rows_p, default 64, directory rows; lg_rows_lp = BSG_SAFE_CLOG2(rows_p).
REQ-005 SHALL derive entry width = tag_width_p+3 ({tag, bp_coh_states_e state}) and row_width_p = tag_sets_per_row_p*assoc_p*entry width. Entry [i][j] sits in the same layout the directory tag checker reads.
REQ-006 SHALL have port clk_i  input  1  clock; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports v_i in 1 and ready_o out 1, the request valid/ready handshake.
REQ-009 SHALL have ports row_addr_i in lg_rows_lp, set_sel_i in 1, way_i in lg(assoc_p), tag_i in tag_width_p and state_i in 3, the request fields.
REQ-010 SHALL have port state_only_i  in  1. When 1, only the state field is updated and the stored tag is kept.
REQ-011 SHALL have ports ram_v_o out 1, ram_w_o out 1, ram_addr_o out lg_rows_lp and ram_data_o out row_width_p, the 1RW synchronous RAM port.
REQ-012 SHALL have port ram_data_i  in  row_width_p. Read data is valid the cycle after a read is issued.
REQ-013 SHALL have port done_o  out  1, a one-cycle pulse in the write cycle.

Function
REQ-014 SHALL implement the FSM states IDLE, RD and WR.
REQ-015 SHALL drive ready_o=1 only in IDLE. A request is accepted when v_i&ready_o, and all request fields are registered at acceptance.
REQ-016 SHALL transition IDLE->RD on acceptance. In RD it drives ram_v_o=1, ram_w_o=0, ram_addr_o=registered row, then transitions to WR.
REQ-017 SHALL, in WR, drive ram_v_o=1, ram_w_o=1, ram_addr_o=registered row and done_o=1, then transition to IDLE.
REQ-018 SHALL, in WR, compute ram_data_o as the source row with only entry [set_sel][way] replaced. The tag is replaced unless state_only; the state is always replaced. All other bits are unchanged.
REQ-019 SHALL use ram_data_i as the source row when WR is entered from RD.
REQ-020 SHALL give a latency of accept at cycle N, read at N+1, write and done_o at N+2, and ready_o again at N+3.
REQ-021 SHALL, in a cycle where v_i=1 and ready_o=0, not accept the request and not modify any state; v_i is held by the requester.
REQ-022 SHALL write state_i=0 (invalid) like any other value, so the entry becomes a non-hit for the checker.
REQ-023 SHALL drive ram_v_o=0 in IDLE; ram_w_o, ram_addr_o and ram_data_o are don't-care when ram_v_o=0.
REQ-024 SHALL register the written row and its address in last_row_r/last_addr_r, setting last_v_r=1 on every WR.

Reset
REQ-025 SHALL, when reset_i=1, enter IDLE on the next edge with ready_o=1, ram_v_o=0, done_o=0 and last_v_r=0.
REQ-026 SHALL, on reset asserted in RD or WR, abandon the request: no further RAM access and no done_o.

Configuration
REQ-027 SHALL, with macro BP_CCE_DIR_WR_BYPASS_EN defined, bypass the read for a request accepted with last_v_r=1 and row_addr_i==last_addr_r. The transition is IDLE->WR directly, with last_row_r as the source row and done_o at N+1.
REQ-028 SHALL, without BP_CCE_DIR_WR_BYPASS_EN, always pass through RD. In that build last_row_r and last_addr_r are not required.

Verification (tag_sets_per_row_p=2, assoc_p=2, tag_width_p=8, rows_p=4)
REQ-029 SHALL cover: RAM row 1 all zero; request row=1, set=1, way=0, tag=0xA5, state=3 -> RD addr 1 at N+1; WR at N+2 with only entry[1][0]={0xA5,3}; done_o pulses once.
REQ-030 SHALL cover: entry[0][1]={0x3C,2}; state_only=1, tag=0xFF, state=0 -> written entry[0][1]={0x3C,0}; all other bits unchanged.
REQ-031 SHALL cover: v_i held high across two back-to-back requests -> second accepted at N+3; ready_o=0 during N+1..N+2.
REQ-032 SHALL cover: reset_i asserted in RD -> no WR, done_o stays 0, IDLE with ready_o=1 the following cycle.
REQ-033 SHALL cover: with BYPASS_EN, two requests to row 2 (set 0 way 0 tag 0x11, then set 1 way 1 tag 0x22) -> second has no RD cycle; its written row contains both entries.
REQ-034 SHALL cover: without BYPASS_EN, the same sequence -> second performs RD.
